// File: rtl/bcd_hms_timer_pkg.sv
// Shared types, digit limits and helpers for the hh:mm:ss BCD timer.
// Values are packed {h1,h0,m1,m0,s1,s0}, one BCD digit per nibble.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } hms_t;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t TENS_MAX  = 4'd5;

  // Value a step must land on to count as terminal: HOUR_LIMIT:59:59 up, 00:00:00 down.
  function automatic hms_t hms_terminal(input logic down, input int unsigned hour_limit);
    hms_t t;
    if (down) begin
      t = hms_t'(24'd0);
    end else begin
      t.h1 = 4'(hour_limit / 32'd10);
      t.h0 = 4'(hour_limit % 32'd10);
      t.m1 = TENS_MAX;
      t.m0 = DIGIT_MAX;
      t.s1 = TENS_MAX;
      t.s0 = DIGIT_MAX;
    end
    return t;
  endfunction

  function automatic logic bcd_hms_valid(input hms_t value, input int unsigned hour_limit);
    logic        digits_ok;
    int unsigned hours;
    digits_ok = (value.s0 <= DIGIT_MAX) && (value.s1 <= TENS_MAX) &&
                (value.m0 <= DIGIT_MAX) && (value.m1 <= TENS_MAX) &&
                (value.h0 <= DIGIT_MAX) && (value.h1 <= DIGIT_MAX);
    hours = (32'(value.h1) * 32'd10) + 32'(value.h0);
    return digits_ok && (hours <= hour_limit);
  endfunction

endpackage

// File: rtl/bcd_hms_timer_step.sv
// Combinational one-second increment/decrement of a packed BCD hh:mm:ss value.
// Carry/borrow ripples seconds -> minutes -> hours; hours wrap at 0 / HOUR_LIMIT.
module bcd_hms_step
  import timer_pkg::*;
#(
  parameter int unsigned HOUR_LIMIT = 99
) (
  input  logic [23:0] value,
  input  logic        dir,
  output logic [23:0] next,
  output logic        at_terminal
);

  localparam bcd_t LIM_H1 = 4'(HOUR_LIMIT / 32'd10);
  localparam bcd_t LIM_H0 = 4'(HOUR_LIMIT % 32'd10);

  // Returns {carry_out, digit}; a digit only moves when carry_in is set.
  function automatic logic [4:0] digit_step(input bcd_t d, input bcd_t dmax,
                                            input logic down, input logic cin);
    logic [4:0] r;
    if (!cin) begin
      r = {1'b0, d};
    end else if (!down) begin
      if (d >= dmax) begin
        r = {1'b1, 4'd0};
      end else begin
        r = {1'b0, d + 4'd1};
      end
    end else begin
      if (d == 4'd0) begin
        r = {1'b1, dmax};
      end else begin
        r = {1'b0, d - 4'd1};
      end
    end
    return r;
  endfunction

  hms_t       cur_s;
  hms_t       nxt_s;
  logic [4:0] s0_s;
  logic [4:0] s1_s;
  logic [4:0] m0_s;
  logic [4:0] m1_s;
  logic [4:0] h0_s;
  logic       hour_wrap_s;

  // Digit chain plus the hour rollover at 00 / HOUR_LIMIT.
  always_comb begin
    cur_s = hms_t'(value);
    nxt_s = cur_s;
    s0_s  = digit_step(cur_s.s0, DIGIT_MAX, dir, 1'b1);
    s1_s  = digit_step(cur_s.s1, TENS_MAX,  dir, s0_s[4]);
    m0_s  = digit_step(cur_s.m0, DIGIT_MAX, dir, s1_s[4]);
    m1_s  = digit_step(cur_s.m1, TENS_MAX,  dir, m0_s[4]);
    h0_s  = digit_step(cur_s.h0, DIGIT_MAX, dir, m1_s[4]);
    if (dir == 1'b0) begin
      hour_wrap_s = (cur_s.h1 == LIM_H1) && (cur_s.h0 == LIM_H0);
    end else begin
      hour_wrap_s = (cur_s.h1 == 4'd0) && (cur_s.h0 == 4'd0);
    end
    nxt_s.s0 = s0_s[3:0];
    nxt_s.s1 = s1_s[3:0];
    nxt_s.m0 = m0_s[3:0];
    nxt_s.m1 = m1_s[3:0];
    nxt_s.h0 = h0_s[3:0];
    if (h0_s[4]) begin
      if (dir == 1'b0) begin
        nxt_s.h1 = cur_s.h1 + 4'd1;
      end else begin
        nxt_s.h1 = cur_s.h1 - 4'd1;
      end
    end else begin
      nxt_s.h1 = cur_s.h1;
    end
    if (m1_s[4] && hour_wrap_s) begin
      if (dir == 1'b0) begin
        nxt_s.h1 = 4'd0;
        nxt_s.h0 = 4'd0;
      end else begin
        nxt_s.h1 = LIM_H1;
        nxt_s.h0 = LIM_H0;
      end
    end else begin
      nxt_s.h1 = nxt_s.h1;
    end
  end

  assign next        = nxt_s;
  assign at_terminal = (nxt_s == hms_terminal(dir, HOUR_LIMIT));

endmodule

// File: rtl/bcd_hms_timer.sv
// hh:mm:ss BCD stopwatch/countdown with pushbutton run/pause, preset load,
// configurable hour limit and wrap-or-stop at terminal count.
module bcd_hms_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned HOUR_LIMIT  = 99,
  parameter bit          WRAP        = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clr,
  input  logic        load,
  input  logic        dir,
  input  logic [23:0] preset,
  output logic [23:0] out,
  output logic        running,
  output logic        sec_tick,
  output logic        done
);

  localparam int unsigned   PW         = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   start_d_r;
  logic                   dir_q_r;
  logic [PW-1:0]          presc_r;
  logic [23:0]            out_r;
  logic                   running_r;
  logic                   sec_tick_r;
  logic                   done_r;

  logic                   fall_s;
  logic                   toggle_s;
  logic                   step_s;
  logic                   at_end_s;
  logic                   preset_ok_s;
  logic [23:0]            step_next_s;
  logic                   step_term_s;
  logic [PW-1:0]          presc_nxt_s;
  logic [23:0]            out_nxt_s;
  logic                   running_nxt_s;
  logic                   run_toggled_s;
  logic                   sec_tick_nxt_s;
  logic                   done_nxt_s;

  bcd_hms_step #(
    .HOUR_LIMIT (HOUR_LIMIT)
  ) u_step (
    .value       (out_r),
    .dir         (dir_q_r),
    .next        (step_next_s),
    .at_terminal (step_term_s)
  );

  // Pushbutton synchroniser (idle high) and falling-edge detect flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r    <= {SYNC_STAGES{1'b1}};
      start_d_r <= 1'b1;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], start};
      start_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign fall_s      = start_d_r & ~sync_r[SYNC_STAGES-1];
  assign at_end_s    = (out_r == hms_terminal(dir_q_r, HOUR_LIMIT));
  // In stop mode a parked terminal value needs clr or load before it can run again.
  assign toggle_s    = fall_s & ~((WRAP == 1'b0) & at_end_s);
  assign step_s      = running_r & (presc_r == PRESC_LAST);
  assign preset_ok_s = bcd_hms_valid(hms_t'(preset), HOUR_LIMIT);

  // Direction is frozen while counting and tracks the pin while stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q_r <= 1'b0;
    end else if (!running_r) begin
      dir_q_r <= dir;
    end
  end

  // Next-state selection in priority order: clr, load, start toggle / step.
  always_comb begin
    out_nxt_s      = out_r;
    presc_nxt_s    = presc_r;
    running_nxt_s  = running_r;
    sec_tick_nxt_s = 1'b0;
    done_nxt_s     = 1'b0;
    run_toggled_s  = running_r ^ toggle_s;
    if (clr) begin
      out_nxt_s     = 24'd0;
      presc_nxt_s   = {PW{1'b0}};
      running_nxt_s = 1'b0;
    end else if (load) begin
      if (preset_ok_s) begin
        out_nxt_s   = preset;
        presc_nxt_s = {PW{1'b0}};
      end else begin
        out_nxt_s   = out_r;
      end
    end else begin
      if (step_s) begin
        out_nxt_s      = step_next_s;
        presc_nxt_s    = {PW{1'b0}};
        sec_tick_nxt_s = 1'b1;
        done_nxt_s     = step_term_s;
        if (step_term_s && (WRAP == 1'b0)) begin
          running_nxt_s = 1'b0;
        end else begin
          running_nxt_s = run_toggled_s;
        end
      end else if (running_r) begin
        presc_nxt_s   = presc_r + PW'(1);
        running_nxt_s = run_toggled_s;
      end else begin
        presc_nxt_s   = presc_r;
        running_nxt_s = run_toggled_s;
      end
    end
  end

  // Counter state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r    <= {PW{1'b0}};
      out_r      <= 24'd0;
      running_r  <= 1'b0;
      sec_tick_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      presc_r    <= presc_nxt_s;
      out_r      <= out_nxt_s;
      running_r  <= running_nxt_s;
      sec_tick_r <= sec_tick_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  assign out      = out_r;
  assign running  = running_r;
  assign sec_tick = sec_tick_r;
  assign done     = done_r;

endmodule

// File: doc/bcd_hms_timer.md
Name: bcd_hms_timer

Overview:
Parametrised hh:mm:ss BCD stopwatch/countdown timer, the next generation of the stage-1 timer.
- Adds up/down counting, configurable hour limit, wrap-or-stop at terminal count, pause/resume with fractional-second retention, preset load, and status pulses.
- Drives the 6-digit seven-segment display path.
- Takes raw active-low pushbutton inputs directly and synchronises them internally.

Parameters:
CLK_HZ, 50000000, clock cycles per one-second step (>=2)
HOUR_LIMIT, 99, maximum hour value, decimal 1..99; hours roll over after this value
WRAP, 1, terminal-count action: 1 = wrap and keep running; 0 = hold terminal value and stop
SYNC_STAGES, 2, synchroniser depth for start (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  asynchronous pushbutton, active-low; falling edge toggles run/pause
clr  in  1  synchronous clear, active-high level
load  in  1  synchronous preset load, active-high
dir  in  1  count direction: 0 = up, 1 = down
preset  in  24  BCD hhmmss value for load, {h1,h0,m1,m0,s1,s0}
out  out  24  BCD hhmmss count value, same packing as preset
running  out  1  1 while counting
sec_tick  out  1  one-cycle pulse on each cycle where out steps
done  out  1  one-cycle pulse when a step lands on the terminal value

Behaviour:
- Reset (rst low, async): out=0, running=0, sec_tick=0, done=0, prescaler=0, dir_q=0, synchroniser flops=1 (idle high).
- Start input path:
  - start passes SYNC_STAGES flops plus one edge-detect flop.
  - A detected 1->0 transition toggles running.
  - Latency from pin fall to running change is SYNC_STAGES+1 cycles.
- Direction: dir_q captures dir only while running=0. Changing dir while running has no effect until a pause.
- Prescaler:
  - Counts 0..CLK_HZ-1 only while running=1; holds its value while paused, so a resumed second completes the remaining fraction.
  - A step occurs on the cycle where prescaler==CLK_HZ-1 and running=1. On that cycle the prescaler returns to 0, out updates, and sec_tick=1.
- Step arithmetic, BCD per digit:
  - Seconds and minutes ones digits count 0..9; tens digits count 0..5.
  - Hours count as a 2-digit BCD value 0..HOUR_LIMIT.
  - Up: carry ripples seconds -> minutes -> hours.
  - Down: borrow ripples the same way; 00 minutes/seconds borrow to 59.
- Terminal value: HOUR_LIMIT:59:59 when counting up; 00:00:00 when counting down.
  - done=1 on the step whose result equals the terminal value.
  - WRAP=0: running clears on that same edge and out holds the terminal value. A start toggle while out equals the terminal value for dir_q is ignored; clr or load is required to restart.
  - WRAP=1: running stays set. The next up step gives 00:00:00; the next down step gives HOUR_LIMIT:59:59.
- Priority, highest first: rst, clr, load, start toggle, step.
  - clr: out=0, prescaler=0, running=0.
  - load:
    - A valid preset (every digit within its range and hours <= HOUR_LIMIT) sets out=preset and prescaler=0; running is unchanged.
    - An invalid preset is ignored entirely, including the prescaler.
  - Start toggle and step in the same cycle: the step uses the pre-toggle running value, so both take effect.
- sec_tick and done are never asserted on clr or load cycles.
- Asynchronous reset mid-count returns every state element to its reset value immediately.

Decomposition:
- Package timer_pkg:
  - BCD digit typedef and hhmmss packed-struct typedef.
  - Digit-limit constants (9, 5).
  - bcd_hms_valid(value, hour_limit) function.
- Sub-module bcd_hms_step:
  - Combinational one-second increment/decrement of a hhmmss value.
  - Inputs: value, dir, HOUR_LIMIT.
  - Outputs: next value, at_terminal.
  - Instantiated once; all state stays in bcd_hms_timer.

Test Plan:
- CLK_HZ=10. Release reset, pulse start low: running=1 after 3 cycles; sec_tick 10 cycles later with out=0x000001.
- Load 0x005959 (dir=0), run one second: out=0x010000, single sec_tick, no done.
- HOUR_LIMIT=23, WRAP=0. Load 0x235958 up, run: out=0x235959, done=1, running=0. A further start press leaves running=0; after clr, start works again.
- WRAP=1. Load 0x000001, dir=1, run: out=0x000000 with done=1, then next step out=0x235959 (HOUR_LIMIT=23) with running still 1.
- Pause at prescaler=4, wait 50 cycles, resume: next sec_tick exactly 6 running cycles after resume. dir toggled while running has no effect.
- Load 0x006A00 -> out unchanged. Start edge coincident with a step -> step applied and running toggled. rst low mid-count -> all outputs 0 in the same cycle.
